piece_cell_sequencer: RTL and testbench

- Scan controller for the tetromino shape ROM. Walks the 4x4 piece window cell by cell and drives the ROM's identifier/col/row inputs.
- For every filled cell it issues a single-port request to the playfield memory:
  - CHECK mode: a read, to detect collision.
  - LOCK mode: a write of the cell's block template.
- Sits between the game-logic FSM (issues start) and the playfield RAM arbiter (answers req/ack).

---
 rtl/piece_cell_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_piece_cell_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/piece_cell_sequencer.sv
// piece_cell_sequencer: walks the 4x4 tetromino window through the shape ROM.
// Each filled cell produces one playfield access: a read in CHECK mode and a
// write of the cell template in LOCK mode.
// Optional build macro COLLISION_EARLY_EXIT_EN: in CHECK mode the first
// collision ends the scan immediately.
module piece_cell_sequencer #(
  parameter int         BOARD_W    = 10,
  parameter int         BOARD_H    = 20,
  parameter logic [1:0] EMPTY_CODE = 2'b11
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       start,
  input  logic       mode,
  input  logic [4:0] piece_id,
  input  logic [5:0] piece_x,
  input  logic [5:0] piece_y,
  output logic [4:0] rom_identifier,
  output logic [2:0] rom_col,
  output logic [2:0] rom_row,
  input  logic [1:0] rom_template,
  output logic       pf_req,
  output logic       pf_we,
  output logic [3:0] pf_x,
  output logic [4:0] pf_y,
  output logic [1:0] pf_wdata,
  input  logic [1:0] pf_rdata,
  input  logic       pf_ack,
  output logic       busy,
  output logic       done,
  output logic       collision
);

`ifdef COLLISION_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_REQ   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic        mode_q, mode_d;
  logic [4:0]  pid_q, pid_d;
  logic [5:0]  px_q, px_d;
  logic [5:0]  py_q, py_d;
  logic        coll_q, coll_d;
  logic [3:0]  pfx_q, pfx_d;
  logic [4:0]  pfy_q, pfy_d;
  logic        pfwe_q, pfwe_d;
  logic [1:0]  pfwd_q, pfwd_d;

  logic [6:0]  tx, ty;
  logic        oob, filled, last;
  state_t      adv_state;
  logic [3:0]  adv_idx;

  // Absolute target cell as 7-bit two's complement plus bounds/fill decode.
  always_comb begin
    tx        = {px_q[5], px_q} + {5'b0, idx_q[1:0]};
    ty        = {py_q[5], py_q} + {5'b0, idx_q[3:2]};
    oob       = tx[6] | (tx[5:0] >= 6'(BOARD_W)) | ty[6] | (ty[5:0] >= 6'(BOARD_H));
    filled    = (rom_template != EMPTY_CODE);
    last      = (idx_q == 4'd15);
    adv_state = last ? S_DONE : S_FETCH;
    adv_idx   = last ? idx_q : idx_q + 4'd1;
  end

  // Next-state and datapath update; "advance" folds the next-cell step into
  // the current cycle so no separate NEXT state is needed.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    pid_d   = pid_q;
    px_d    = px_q;
    py_d    = py_q;
    coll_d  = coll_q;
    pfx_d   = pfx_q;
    pfy_d   = pfy_q;
    pfwe_d  = pfwe_q;
    pfwd_d  = pfwd_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = mode;
          pid_d   = piece_id;
          px_d    = piece_x;
          py_d    = piece_y;
          coll_d  = 1'b0;
          idx_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (!filled) begin
          state_d = adv_state;
          idx_d   = adv_idx;
        end else if (oob) begin
          coll_d = 1'b1;
          if (EARLY_EXIT && !mode_q) begin
            state_d = S_DONE;
          end else begin
            state_d = adv_state;
            idx_d   = adv_idx;
          end
        end else begin
          pfx_d   = tx[3:0];
          pfy_d   = ty[4:0];
          pfwe_d  = mode_q;
          pfwd_d  = rom_template;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (pf_ack) begin
          if (!mode_q && (pf_rdata != EMPTY_CODE)) begin
            coll_d = 1'b1;
            if (EARLY_EXIT) begin
              state_d = S_DONE;
            end else begin
              state_d = adv_state;
              idx_d   = adv_idx;
            end
          end else begin
            state_d = adv_state;
            idx_d   = adv_idx;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; asynchronous reset aborts any scan.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      mode_q  <= 1'b0;
      pid_q   <= '0;
      px_q    <= '0;
      py_q    <= '0;
      coll_q  <= 1'b0;
      pfx_q   <= '0;
      pfy_q   <= '0;
      pfwe_q  <= 1'b0;
      pfwd_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      pid_q   <= pid_d;
      px_q    <= px_d;
      py_q    <= py_d;
      coll_q  <= coll_d;
      pfx_q   <= pfx_d;
      pfy_q   <= pfy_d;
      pfwe_q  <= pfwe_d;
      pfwd_q  <= pfwd_d;
    end
  end

  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign pf_req         = (state_q == S_REQ);
  assign collision      = coll_q;
  assign pf_x           = pfx_q;
  assign pf_y           = pfy_q;
  assign pf_we          = pfwe_q;
  assign pf_wdata       = pfwd_q;
  assign rom_identifier = busy ? pid_q : '0;
  assign rom_col        = busy ? {1'b0, idx_q[1:0]} : '0;
  assign rom_row        = busy ? {1'b0, idx_q[3:2]} : '0;

endmodule

// File: tb/tb_piece_cell_sequencer.sv
// Directed bench for piece_cell_sequencer with a behavioural shape ROM and
// playfield responder (configurable ack delay, one optional occupied cell).
module tb_piece_cell_sequencer;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b1;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [4:0] piece_id = '0;
  logic [5:0] piece_x = '0;
  logic [5:0] piece_y = '0;
  logic [4:0] rom_identifier;
  logic [2:0] rom_col, rom_row;
  logic [1:0] rom_template;
  logic       pf_req, pf_we, pf_ack;
  logic [3:0] pf_x;
  logic [4:0] pf_y;
  logic [1:0] pf_wdata, pf_rdata;
  logic       busy, done, collision;

  always #5 Clk = ~Clk;

  piece_cell_sequencer #(
    .BOARD_W(10),
    .BOARD_H(20),
    .EMPTY_CODE(2'b11)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .mode(mode),
    .piece_id(piece_id), .piece_x(piece_x), .piece_y(piece_y),
    .rom_identifier(rom_identifier), .rom_col(rom_col), .rom_row(rom_row),
    .rom_template(rom_template), .pf_req(pf_req), .pf_we(pf_we),
    .pf_x(pf_x), .pf_y(pf_y), .pf_wdata(pf_wdata), .pf_rdata(pf_rdata),
    .pf_ack(pf_ack), .busy(busy), .done(done), .collision(collision)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Shape ROM: O (id 0), I flat (id 4), S flat (id 12), T (id 16).
  function automatic logic [1:0] rom_fn(input logic [4:0] id, input logic [2:0] r, input logic [2:0] c);
    logic [1:0] t;
    t = 2'b11;
    case (id)
      5'b00000: if ((r == 3'd2 || r == 3'd3) && (c == 3'd1 || c == 3'd2)) t = 2'b00;
      5'b00100: if (r == 3'd2) t = 2'b10;
      5'b01100: if ((r == 3'd1 && (c == 3'd1 || c == 3'd2)) ||
                    (r == 3'd2 && (c == 3'd0 || c == 3'd1))) t = 2'b10;
      5'b10000: if ((r == 3'd1 && c <= 3'd2) || (r == 3'd2 && c == 3'd1)) t = 2'b01;
      default:  t = 2'b11;
    endcase
    return t;
  endfunction

  always_comb rom_template = rom_fn(rom_identifier, rom_row, rom_col);

  logic       hit_en = 1'b0;
  logic [3:0] hit_x = '0;
  logic [4:0] hit_y = '0;
  always_comb pf_rdata = (hit_en && pf_x == hit_x && pf_y == hit_y) ? 2'b01 : 2'b11;

  int ack_delay = 0;
  int req_cnt = 0;
  always_comb pf_ack = pf_req && (req_cnt == ack_delay);

  logic [11:0] cur;
  assign cur = {pf_we, pf_wdata, pf_x, pf_y};

  logic [11:0] acc_log[$];
  int          len_log[$];
  int          stab_err = 0;
  logic [11:0] cap = '0;

  // Playfield responder: logs completed accesses and their req length, and
  // counts address/data changes while a request is outstanding.
  always @(posedge Clk) begin
    if (pf_req) begin
      if (req_cnt == 0) cap <= cur;
      else if (cur !== cap) stab_err++;
      if (pf_ack) begin
        acc_log.push_back(cur);
        len_log.push_back(req_cnt + 1);
        req_cnt <= 0;
      end else begin
        req_cnt <= req_cnt + 1;
      end
    end else begin
      req_cnt <= 0;
    end
  end

  function automatic logic [11:0] acc(input logic we, input logic [1:0] wd, input int x, input int y);
    return {we, wd, 4'(x), 5'(y)};
  endfunction

  function automatic logic [11:0] log_at(input int i);
    return (i < acc_log.size()) ? acc_log[i] : 12'hfff;
  endfunction

  function automatic int len_at(input int i);
    return (i < len_log.size()) ? len_log[i] : -1;
  endfunction

  logic [26:0] outs;
  assign outs = {busy, done, collision, pf_req, pf_we, pf_x, pf_y, pf_wdata,
                 rom_identifier, rom_col, rom_row};

  int base;
  int lat;

  // Issue one start, measure edges from the start edge to done, check the
  // collision clear on entry and the single-cycle done pulse.
  task automatic run_scan(input string tag, input logic m, input logic [4:0] id,
                          input logic [5:0] x, input logic [5:0] y, output int l);
    base = acc_log.size();
    @(posedge Clk); #1;
    mode = m; piece_id = id; piece_x = x; piece_y = y; start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    check_eq({tag, "_clr"}, {busy, collision}, 2'b10);
    l = -1;
    for (int n = 2; n <= 200; n++) begin
      @(posedge Clk); #1;
      if (done) begin
        l = n;
        break;
      end
    end
    @(posedge Clk); #1;
    check_eq({tag, "_pulse"}, {done, busy}, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    #2 Reset_n = 1'b0;
    #10 check_eq("rst_outs", 32'(outs), 32'd0);
    #10 Reset_n = 1'b1;

    // I flat at x=8: (8,2),(9,2) read, (10,2) out of bounds.
    run_scan("i", 1'b0, 5'b00100, 6'd8, 6'd0, lat);
`ifdef COLLISION_EARLY_EXIT_EN
    check_eq("i_lat", lat, 14);
`else
    check_eq("i_lat", lat, 19);
`endif
    check_eq("i_coll", collision, 1'b1);
    check_eq("i_cnt", acc_log.size() - base, 2);
    check_eq("i_acc0", log_at(base), acc(1'b0, 2'b10, 8, 2));
    check_eq("i_acc1", log_at(base + 1), acc(1'b0, 2'b10, 9, 2));
    repeat (3) @(posedge Clk);
    #1 check_eq("i_hold", collision, 1'b1);

    // O LOCK at x=3, immediate ack.
    run_scan("o", 1'b1, 5'b00000, 6'd3, 6'd0, lat);
    check_eq("o_lat", lat, 21);
    check_eq("o_coll", collision, 1'b0);
    check_eq("o_cnt", acc_log.size() - base, 4);
    check_eq("o_w0", log_at(base),     acc(1'b1, 2'b00, 4, 2));
    check_eq("o_w1", log_at(base + 1), acc(1'b1, 2'b00, 5, 2));
    check_eq("o_w2", log_at(base + 2), acc(1'b1, 2'b00, 4, 3));
    check_eq("o_w3", log_at(base + 3), acc(1'b1, 2'b00, 5, 3));

    // T CHECK, ack on the fourth cycle of each request.
    ack_delay = 3;
    begin
      int s0;
      s0 = stab_err;
      run_scan("t", 1'b0, 5'b10000, 6'd0, 6'd0, lat);
      check_eq("t_stab", stab_err - s0, 0);
    end
    check_eq("t_lat", lat, 33);
    check_eq("t_coll", collision, 1'b0);
    check_eq("t_cnt", acc_log.size() - base, 4);
    check_eq("t_r0", log_at(base),     acc(1'b0, 2'b01, 0, 1));
    check_eq("t_r1", log_at(base + 1), acc(1'b0, 2'b01, 1, 1));
    check_eq("t_r2", log_at(base + 2), acc(1'b0, 2'b01, 2, 1));
    check_eq("t_r3", log_at(base + 3), acc(1'b0, 2'b01, 1, 2));
    for (int k = 0; k < 4; k++) check_eq($sformatf("t_len%0d", k), len_at(base + k), 4);

    // S CHECK at y=17 with an occupied cell at (1,19), the last filled cell.
    ack_delay = 0;
    hit_en = 1'b1; hit_x = 4'd1; hit_y = 5'd19;
    run_scan("s", 1'b0, 5'b01100, 6'd0, 6'd17, lat);
`ifdef COLLISION_EARLY_EXIT_EN
    check_eq("s_lat", lat, 15);
`else
    check_eq("s_lat", lat, 21);
`endif
    check_eq("s_coll", collision, 1'b1);
    check_eq("s_cnt", acc_log.size() - base, 4);
    check_eq("s_r3", log_at(base + 3), acc(1'b0, 2'b10, 1, 19));
    hit_en = 1'b0;

    // start while busy is ignored; asynchronous reset mid-request.
    ack_delay = 3;
    @(posedge Clk); #1;
    mode = 1'b0; piece_id = 5'b10000; piece_x = 6'd0; piece_y = 6'd0; start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    @(posedge Clk); #1;
    mode = 1'b1; piece_id = 5'b00000; piece_x = 6'd3; start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (pf_req) break;
      @(posedge Clk); #1;
    end
    check_eq("busy_req", pf_req, 1'b1);
    check_eq("busy_ign", cur, acc(1'b0, 2'b01, 0, 1));
    #2 Reset_n = 1'b0;
    #1 check_eq("rst_async", 32'(outs), 32'd0);
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    begin
      int nact;
      nact = 0;
      for (int n = 0; n < 6; n++) begin
        @(posedge Clk); #1;
        if (pf_req || busy) nact++;
      end
      check_eq("post_rst_idle", nact, 0);
    end

    ack_delay = 0;
    run_scan("o2", 1'b1, 5'b00000, 6'd3, 6'd0, lat);
    check_eq("o2_lat", lat, 21);
    check_eq("o2_coll", collision, 1'b0);
    check_eq("o2_cnt", acc_log.size() - base, 4);
    check_eq("o2_w0", log_at(base), acc(1'b1, 2'b00, 4, 2));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
